// File: rtl/taus88_rng.sv
// Tausworthe-88 combined uniform RNG: three LFSR-like components XORed into
// one registered 32-bit word per clock, with a runtime reload of S1.
module taus88_rng #(
    parameter logic [31:0] S1_INIT = 32'h0000_0002,
    parameter logic [31:0] S2_INIT = 32'h0000_0008,
    parameter logic [31:0] S3_INIT = 32'h0000_0010
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] seed,
    input  logic        re_seed,
    output logic [31:0] rnd
);

    logic [31:0] s1, s2, s3;
    logic [31:0] b1, b2, b3;
    logic [31:0] s1_nxt, s2_nxt, s3_nxt;
    logic [31:0] s1_load;

    always_comb begin
        b1     = ((s1 << 13) ^ s1) >> 19;
        s1_nxt = ((s1 & 32'hFFFF_FFFE) << 12) ^ b1;
        b2     = ((s2 << 2) ^ s2) >> 25;
        s2_nxt = ((s2 & 32'hFFFF_FFF8) << 4) ^ b2;
        b3     = ((s3 << 3) ^ s3) >> 11;
        s3_nxt = ((s3 & 32'hFFFF_FFF0) << 17) ^ b3;
    end

    // Seeds 0 and 1 would collapse S1 to the all-zero fixed point.
    assign s1_load = (seed < 32'd2) ? S1_INIT : seed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1  <= S1_INIT;
            s2  <= S2_INIT;
            s3  <= S3_INIT;
            rnd <= '0;
        end else if (re_seed) begin
            s1  <= s1_load;
            s2  <= S2_INIT;
            s3  <= S3_INIT;
            rnd <= '0;
        end else begin
            s1  <= s1_nxt;
            s2  <= s2_nxt;
            s3  <= s3_nxt;
            rnd <= s1_nxt ^ s2_nxt ^ s3_nxt;
        end
    end

endmodule

// File: tb/tb_taus88_rng.sv
// Directed bench for taus88_rng: hand-computed post-reset words, reseed
// behaviour, async reset, and a long run against a reference step model.
module tb_taus88_rng;

    logic        clk;
    logic        rst_n;
    logic [31:0] seed;
    logic        re_seed;
    logic [31:0] rnd;

    int checks = 0;
    int errors = 0;

    logic [31:0] m1, m2, m3, mrnd;
    logic [31:0] seq_a [10];
    logic [31:0] seq_b [10];

    taus88_rng dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .seed   (seed),
        .re_seed(re_seed),
        .rnd    (rnd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Reference taus88 step, written straight from the L'Ecuyer recurrence.
    task automatic model_step();
        logic [31:0] b;
        b  = ((m1 << 13) ^ m1) >> 19;
        m1 = ((m1 & 32'hFFFF_FFFE) << 12) ^ b;
        b  = ((m2 << 2) ^ m2) >> 25;
        m2 = ((m2 & 32'hFFFF_FFF8) << 4) ^ b;
        b  = ((m3 << 3) ^ m3) >> 11;
        m3 = ((m3 & 32'hFFFF_FFF0) << 17) ^ b;
        mrnd = m1 ^ m2 ^ m3;
    endtask

    task automatic edge_s();
        @(posedge clk);
        #1;
    endtask

    task automatic model_seed(input logic [31:0] s);
        m1 = (s < 32'd2) ? 32'h2 : s;
        m2 = 32'h8;
        m3 = 32'h10;
    endtask

    initial begin
        rst_n   = 1'b0;
        re_seed = 1'b0;
        seed    = 32'hFFFF_FFFF;
        #12;
        check("reset_rnd", rnd, 32'h0);
        rst_n = 1'b1;

        // Test 1: post-reset sequence; seed toggles but re_seed=0.
        edge_s(); check("rst_edge1", rnd, 32'h0020_2080);
        seed = 32'h1234_5678;
        edge_s(); check("rst_edge2", rnd, 32'h0200_2C80);

        // Test 2: reseed with 2 reproduces reset sequence.
        seed = 32'h2; re_seed = 1'b1;
        edge_s(); check("seed2_load", rnd, 32'h0);
        re_seed = 1'b0; seed = 32'hA5A5_A5A5;
        edge_s(); check("seed2_e1", rnd, 32'h0020_2080);
        edge_s(); check("seed2_e2", rnd, 32'h0200_2C80);

        // Test 3: invalid seeds 0 and 1 fall back to S1_INIT.
        for (int s = 0; s < 2; s++) begin
            seed = 32'(s); re_seed = 1'b1;
            edge_s(); check("bad_seed_load", rnd, 32'h0);
            re_seed = 1'b0;
            edge_s(); check("bad_seed_e1", rnd, 32'h0020_2080);
            edge_s(); check("bad_seed_e2", rnd, 32'h0200_2C80);
        end

        // Held re_seed: reload repeats, stepping resumes after release.
        seed = 32'h2; re_seed = 1'b1;
        for (int i = 0; i < 3; i++) begin
            edge_s(); check("held_load", rnd, 32'h0);
        end
        re_seed = 1'b0;
        edge_s(); check("held_e1", rnd, 32'h0020_2080);

        // Test 4: reseed DEADBEEF from two different prior states.
        for (int i = 0; i < 7; i++) edge_s();
        seed = 32'hDEAD_BEEF; re_seed = 1'b1;
        edge_s(); check("db_load_a", rnd, 32'h0);
        re_seed = 1'b0;
        model_seed(32'hDEAD_BEEF);
        for (int i = 0; i < 10; i++) begin
            edge_s(); model_step();
            seq_a[i] = rnd;
            check("db_model_a", rnd, mrnd);
        end
        for (int i = 0; i < 23; i++) edge_s();
        re_seed = 1'b1;
        edge_s(); check("db_load_b", rnd, 32'h0);
        re_seed = 1'b0;
        for (int i = 0; i < 10; i++) begin
            edge_s();
            seq_b[i] = rnd;
            check("db_repeat", seq_b[i], seq_a[i]);
        end

        // Test 5: async reset between edges clears rnd immediately.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst", rnd, 32'h0);
        // Reset wins over a simultaneous reseed.
        re_seed = 1'b1; seed = 32'hDEAD_BEEF;
        edge_s(); check("rst_over_seed", rnd, 32'h0);
        re_seed = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        edge_s(); check("rerst_e1", rnd, 32'h0020_2080);
        edge_s(); check("rerst_e2", rnd, 32'h0200_2C80);

        // Test 6: 10k-cycle run against the model with random unused seeds.
        model_seed(32'h2);
        model_step(); model_step();
        for (int i = 0; i < 10000; i++) begin
            seed = $urandom;
            edge_s(); model_step();
            check("long_run", rnd, mrnd);
            checks++;
            assert (rnd !== 32'h0) else begin
                errors++;
                $error("FAIL long_run_zero: observed %08h expected nonzero", rnd);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
